// File: rtl/note_detector.sv
// rtl/note_detector.sv - pitch period to nearest equal-tempered note/octave
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   reset        asynchronous, active-high; clears all state
//   sig_in       asynchronous pitch square wave (comparator output)
//   note         detected note 0 (C) .. 11 (B), registered
//   octave       detected octave 0..7, registered
//   valid        one-cycle pulse when a conversion completes
//   no_signal    high while no rising edge has been seen within the timeout
//   out_of_range high when the last conversion was above octave 7 / B
//   period       last accepted period in clk cycles (debug)
module note_detector #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sig_in,
  output logic [3:0]  note,
  output logic [2:0]  octave,
  output logic        valid,
  output logic        no_signal,
  output logic        out_of_range,
  output logic [21:0] period
);

  // Quarter-tone boundaries of octave 0 are tabulated at 50 MHz and
  // rescaled (rounded) to CLK_HZ; at 50 MHz the values pass through exactly.
  localparam longint unsigned REF_HZ = 64'd50_000_000;

  function automatic logic [21:0] scale(input longint unsigned t_ref);
    longint unsigned v;
    v = (t_ref * 64'(CLK_HZ) + REF_HZ / 2) / REF_HZ;
    return 22'(v);
  endfunction

  localparam logic [21:0] T0   = scale(64'd3_147_406);
  localparam logic [21:0] T1   = scale(64'd2_970_755);
  localparam logic [21:0] T2   = scale(64'd2_804_019);
  localparam logic [21:0] T3   = scale(64'd2_646_642);
  localparam logic [21:0] T4   = scale(64'd2_498_097);
  localparam logic [21:0] T5   = scale(64'd2_357_890);
  localparam logic [21:0] T6   = scale(64'd2_225_552);
  localparam logic [21:0] T7   = scale(64'd2_100_641);
  localparam logic [21:0] T8   = scale(64'd1_982_741);
  localparam logic [21:0] T9   = scale(64'd1_871_458);
  localparam logic [21:0] T10  = scale(64'd1_766_421);
  localparam logic [21:0] T11  = scale(64'd1_667_280);
  localparam logic [21:0] T12  = scale(64'd1_573_703);
  localparam logic [21:0] TMAX = T0 + 22'd1;

  // Index 0 is never searched; anything past 11 maps to the last boundary.
  function automatic logic [21:0] thr_at(input logic [3:0] idx);
    logic [21:0] t;
    case (idx)
      4'd1:    t = T1;
      4'd2:    t = T2;
      4'd3:    t = T3;
      4'd4:    t = T4;
      4'd5:    t = T5;
      4'd6:    t = T6;
      4'd7:    t = T7;
      4'd8:    t = T8;
      4'd9:    t = T9;
      4'd10:   t = T10;
      4'd11:   t = T11;
      default: t = T12;
    endcase
    return t;
  endfunction

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    NORM   = 2'd1,
    SEARCH = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [21:0] w_q, w_d;
  logic [2:0]  k_q, k_d;
  logic [3:0]  i_q, i_d;
  logic [3:0]  n_q, n_d;
  logic        err_q, err_d;

  // Input conditioning: two-flop synchronizer plus one flop for edge detect.
  logic sync1, sync2, sync2_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
    end else begin
      sync1   <= sig_in;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  logic        rise;
  logic        timeout;
  logic        accept;
  logic        discard;
  logic [21:0] cnt;
  logic [21:0] p_meas;

  assign rise    = sync2 & ~sync2_d;
  // The edge cycle itself counts, so the period is one more than the count.
  assign p_meas  = cnt + 22'd1;
  // Fires on the cycle the counter steps onto its saturation value.
  assign timeout = ~rise & (cnt == T0);
  // A period of exactly T0+1 slipped in just before the timeout; it is
  // longer than the table covers, so it only restarts the counter.
  assign accept  = rise & ~discard & (state_q == IDLE) & (p_meas <= T0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= 22'd0;
      discard   <= 1'b1;
      no_signal <= 1'b1;
      period    <= 22'd0;
    end else begin
      if (rise) begin
        cnt <= 22'd0;
      end else if (cnt != TMAX) begin
        cnt <= cnt + 22'd1;
      end

      if (timeout) begin
        discard <= 1'b1;
      end else if (rise) begin
        discard <= 1'b0;
      end

      if (accept) begin
        no_signal <= 1'b0;
        period    <= p_meas;
      end else if (timeout) begin
        no_signal <= 1'b1;
      end
    end
  end

  // 2W needs bit 22 even though W itself never exceeds T0.
  logic [22:0] w2;
  logic        fits;

  assign w2   = {w_q, 1'b0};
  assign fits = (w2 <= {1'b0, T0});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      w_q     <= 22'd0;
      k_q     <= 3'd0;
      i_q     <= 4'd0;
      n_q     <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      k_q     <= k_d;
      i_q     <= i_d;
      n_q     <= n_d;
      err_q   <= err_d;
    end
  end

  // Normalize the period into octave 0 by doubling (k = octave), then walk
  // the descending boundary table until W exceeds a boundary.
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    k_d     = k_q;
    i_d     = i_q;
    n_d     = n_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          w_d     = p_meas;
          k_d     = 3'd0;
          err_d   = 1'b0;
          state_d = NORM;
        end
      end

      NORM: begin
        if (fits) begin
          if (k_q != 3'd7) begin
            w_d = w2[21:0];
            k_d = k_q + 3'd1;
          end else begin
            // Would need an eighth doubling: above B7.
            err_d   = 1'b1;
            state_d = DONE;
          end
        end else begin
          i_d     = 4'd1;
          state_d = SEARCH;
        end
      end

      SEARCH: begin
        // i == 12 catches W at or below the last boundary (rounding edge).
        if ((w_q > thr_at(i_q)) || (i_q == 4'd12)) begin
          n_d     = i_q - 4'd1;
          state_d = DONE;
        end else begin
          i_d = i_q + 4'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Results are registered out of DONE so they change together with valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      note         <= 4'd0;
      octave       <= 3'd0;
      valid        <= 1'b0;
      out_of_range <= 1'b0;
    end else begin
      valid <= (state_q == DONE);
      if (state_q == DONE) begin
        if (err_q) begin
          out_of_range <= 1'b1;
        end else begin
          note         <= n_q;
          octave       <= k_q;
          out_of_range <= 1'b0;
        end
      end
    end
  end

endmodule
